// File: rtl/offnariscv_pkg.sv
// Shared types and constants for the ACE read-path arbiter.
package offnariscv_pkg;

    localparam int ACE_AR_ADDR_WIDTH  = 32;
    localparam int ACE_XID_WIDTH      = 4;
    localparam int ACE_RRESP_WIDTH    = 4;

    localparam int ACE_RD_ARB_NUM_REQ = 2;
    localparam int ACE_RD_ARB_IFU     = 0;
    localparam int ACE_RD_ARB_LSU     = 1;

    typedef struct packed {
        logic [ACE_AR_ADDR_WIDTH-1:0] addr;
        logic [7:0]                   len;
        logic [2:0]                   size;
        logic [1:0]                   burst;
        logic [3:0]                   snoop;
        logic [1:0]                   domain;
    } ace_ar_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-input round-robin grant. The pointer names the requester that has
// priority; it moves to the non-winner whenever a grant is accepted.
module rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic prio;

    // Grant the pointed-to requester, otherwise fall back to the other one
    always_comb begin
        grant = '0;
        if (req[prio]) begin
            grant[prio] = 1'b1;
        end else if (req[~prio]) begin
            grant[~prio] = 1'b1;
        end
    end

    // Hand priority to the requester that lost on every accepted grant
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= ~grant[1];
        end
    end

endmodule

// File: rtl/ace_rd_arbiter.sv
// Shares one ACE read manager port between the L1I fill path (requester 0)
// and the L1D/LSU fill path (requester 1). AR requests are arbitrated into a
// one-entry output register and tagged with the requester index in ARID;
// R beats are steered back by RID[0]; RACK is generated locally.
// Build option: define ACE_RD_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 always wins when eligible); otherwise round-robin.
module ace_rd_arbiter
    import offnariscv_pkg::*;
#(
    parameter int ACE_XDATA_WIDTH  = 256,
    parameter int ACE_AXADDR_WIDTH = 32,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,

    input  ace_ar_req_t [ACE_RD_ARB_NUM_REQ-1:0]       s_ar_req,
    input  logic        [ACE_RD_ARB_NUM_REQ-1:0]       s_arvalid,
    output logic        [ACE_RD_ARB_NUM_REQ-1:0]       s_arready,
    output logic        [ACE_XDATA_WIDTH-1:0]          s_rdata,
    output logic        [ACE_RRESP_WIDTH-1:0]          s_rresp,
    output logic                                       s_rlast,
    output logic        [ACE_RD_ARB_NUM_REQ-1:0]       s_rvalid,
    input  logic        [ACE_RD_ARB_NUM_REQ-1:0]       s_rready,

    output logic        [ACE_XID_WIDTH-1:0]            m_arid,
    output ace_ar_req_t                                m_ar_req,
    output logic                                       m_arvalid,
    input  logic                                       m_arready,
    input  logic        [ACE_XID_WIDTH-1:0]            m_rid,
    input  logic        [ACE_XDATA_WIDTH-1:0]          m_rdata,
    input  logic        [ACE_RRESP_WIDTH-1:0]          m_rresp,
    input  logic                                       m_rlast,
    input  logic                                       m_rvalid,
    output logic                                       m_rready,
    output logic                                       m_rack
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // The AR payload layout is fixed by the package struct
    if (ACE_AXADDR_WIDTH != ACE_AR_ADDR_WIDTH) begin : g_addr_width_check
        $error("ACE_AXADDR_WIDTH must match offnariscv_pkg::ACE_AR_ADDR_WIDTH");
    end

    logic [CNT_W-1:0] cnt [ACE_RD_ARB_NUM_REQ];
    logic [1:0]       eligible;
    logic [1:0]       grant;
    logic             load_ok;
    logic             ar_hs;
    logic             winner;
    logic             r_sel;
    logic             r_hs;
    logic             rlast_hs;
    logic [1:0]       r_dec;
    logic             unused_rid_hi;

    assign r_sel         = m_rid[0];
    assign unused_rid_hi = ^m_rid[ACE_XID_WIDTH-1:1];

    // A requester may compete only while it has a free credit
    always_comb begin
        for (int unsigned i = 0; i < ACE_RD_ARB_NUM_REQ; i++) begin
            eligible[i] = s_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

`ifdef ACE_RD_ARB_FIXED_PRIO_EN
    // Instruction fetch always wins when it is eligible
    always_comb begin
        grant = '0;
        if (eligible[ACE_RD_ARB_IFU]) begin
            grant[ACE_RD_ARB_IFU] = 1'b1;
        end else if (eligible[ACE_RD_ARB_LSU]) begin
            grant[ACE_RD_ARB_LSU] = 1'b1;
        end
    end
`else
    rr_arbiter u_rr_arbiter (
        .clk    (clk),
        .rst    (rst),
        .req    (eligible),
        .accept (ar_hs),
        .grant  (grant)
    );
`endif

    // The output register can take a new request when empty or draining
    assign load_ok   = !m_arvalid || m_arready;
    assign s_arready = load_ok ? grant : '0;
    assign ar_hs     = |s_arready;
    assign winner    = s_arready[1];

    // R path: zero-latency steering by RID[0], payload broadcast
    assign s_rvalid[0] = m_rvalid && !r_sel;
    assign s_rvalid[1] = m_rvalid &&  r_sel;
    assign m_rready    = s_rready[r_sel];
    assign s_rdata     = m_rdata;
    assign s_rresp     = m_rresp;
    assign s_rlast     = m_rlast;

    assign r_hs     = m_rvalid && m_rready;
    assign rlast_hs = r_hs && m_rlast;
    assign r_dec    = rlast_hs ? (r_sel ? 2'b10 : 2'b01) : 2'b00;

    // AR output register: loads the winner, holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            m_arvalid <= 1'b0;
            m_arid    <= '0;
            m_ar_req  <= '0;
        end else if (load_ok) begin
            m_arvalid <= ar_hs;
            if (ar_hs) begin
                m_arid   <= ACE_XID_WIDTH'(winner);
                m_ar_req <= s_ar_req[winner];
            end
        end
    end

    // Per-requester outstanding counters; simultaneous inc and dec cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ACE_RD_ARB_NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ACE_RD_ARB_NUM_REQ; i++) begin
                if (s_arready[i] && !r_dec[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (!s_arready[i] && r_dec[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // One RACK pulse for each last beat accepted in the previous cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            m_rack <= 1'b0;
        end else begin
            m_rack <= rlast_hs;
        end
    end

endmodule

// File: tb/tb_ace_rd_arbiter.sv
// Self-checking bench for ace_rd_arbiter: directed scenarios followed by
// random traffic, all checked against a transaction-level reference model.
module tb_ace_rd_arbiter;
    import offnariscv_pkg::*;

    localparam int DW   = 256;
    localparam int MAXO = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    ace_ar_req_t [1:0]           s_ar_req;
    logic [1:0]                  s_arvalid;
    logic [1:0]                  s_arready;
    logic [DW-1:0]               s_rdata;
    logic [ACE_RRESP_WIDTH-1:0]  s_rresp;
    logic                        s_rlast;
    logic [1:0]                  s_rvalid;
    logic [1:0]                  s_rready;
    logic [ACE_XID_WIDTH-1:0]    m_arid;
    ace_ar_req_t                 m_ar_req;
    logic                        m_arvalid;
    logic                        m_arready;
    logic [ACE_XID_WIDTH-1:0]    m_rid;
    logic [DW-1:0]               m_rdata;
    logic [ACE_RRESP_WIDTH-1:0]  m_rresp;
    logic                        m_rlast;
    logic                        m_rvalid;
    logic                        m_rready;
    logic                        m_rack;

    always #5 clk = ~clk;

    ace_rd_arbiter #(
        .ACE_XDATA_WIDTH  (DW),
        .ACE_AXADDR_WIDTH (32),
        .MAX_OUTSTANDING  (MAXO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_ar_req  (s_ar_req),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .m_arid    (m_arid),
        .m_ar_req  (m_ar_req),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rid     (m_rid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rack    (m_rack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: in-flight count per requester, the pending
    // output-register entry, the last winner, and the expected RACK.
    int          cnt_m [2];
    int          last_win;
    bit          ov;
    int          oid;
    ace_ar_req_t oreq;
    bit          rack_m;

    logic [1:0]  obs_ready;
    logic [1:0]  obs_rvalid;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ace_ar_req_t rand_req();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[$bits(ace_ar_req_t)-1:0];
    endfunction

    task automatic idle_inputs();
        s_arvalid = '0;
        s_ar_req  = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
    endtask

    // One clock cycle: check combinational outputs against the model,
    // clock, advance the model, then check the registered outputs.
    task automatic step();
        bit         e0, e1, load, was_rst, rhs;
        int         win;
        logic [1:0] exp_rdy;
        #1;
        was_rst = rst;
        load = !ov || m_arready;
        e0 = s_arvalid[0] && (cnt_m[0] < MAXO);
        e1 = s_arvalid[1] && (cnt_m[1] < MAXO);
        win = -1;
        if (load) begin
`ifdef ACE_RD_ARB_FIXED_PRIO_EN
            if (e0) win = 0; else if (e1) win = 1;
`else
            if (last_win == 1) begin
                if (e0) win = 0; else if (e1) win = 1;
            end else begin
                if (e1) win = 1; else if (e0) win = 0;
            end
`endif
        end
        exp_rdy = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
        obs_ready  = s_arready;
        obs_rvalid = s_rvalid;
        if (!was_rst) begin
            check("s_arready", s_arready, exp_rdy);
            check("s_rvalid", s_rvalid, m_rvalid ? (m_rid[0] ? 2'b10 : 2'b01) : 2'b00);
            check("m_rready", m_rready, s_rready[m_rid[0]]);
            if (m_rvalid) begin
                check("s_rdata", s_rdata, m_rdata);
                check("s_rresp_last", {s_rresp, s_rlast}, {m_rresp, m_rlast});
            end
        end
        rhs = m_rvalid && s_rready[m_rid[0]];
        @(posedge clk);
        if (was_rst) begin
            ov = 0; oid = 0; oreq = '0; rack_m = 0;
            cnt_m[0] = 0; cnt_m[1] = 0; last_win = 1;
        end else begin
            if (win >= 0) cnt_m[win]++;
            if (rhs && m_rlast) cnt_m[m_rid[0]]--;
            rack_m = rhs && m_rlast;
            if (load) begin
                ov = (win >= 0);
                if (win >= 0) begin
                    oid = win;
                    oreq = s_ar_req[win];
                    last_win = win;
                end
            end
        end
        #1;
        check("m_arvalid", m_arvalid, ov);
        check("m_rack", m_rack, rack_m);
        if (ov || was_rst) begin
            check("m_arid", m_arid, 4'(oid));
            check("m_ar_req", m_ar_req, oreq);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_random();
        int sel;
        s_arvalid   = 2'($urandom);
        s_ar_req[0] = rand_req();
        s_ar_req[1] = rand_req();
        m_arready   = ($urandom % 4) != 0;
        s_rready    = 2'($urandom);
        m_rdata     = {8{$urandom}};
        m_rresp     = 4'($urandom);
        m_rlast     = 1'($urandom);
        if (cnt_m[0] > 0 || cnt_m[1] > 0) begin
            if (cnt_m[0] > 0 && cnt_m[1] > 0) sel = int'($urandom % 2);
            else sel = (cnt_m[1] > 0) ? 1 : 0;
            m_rvalid = 1'($urandom);
            m_rid    = {3'($urandom), 1'(sel)};
        end else begin
            m_rvalid = 1'b0;
            m_rid    = 4'($urandom);
        end
    endtask

    initial begin
        ov = 0; oid = 0; oreq = '0; rack_m = 0;
        cnt_m[0] = 0; cnt_m[1] = 0; last_win = 1;

        do_reset();

        // Single read from requester 0
        s_ar_req[0] = rand_req();
        s_ar_req[0].addr = 32'h8000_0040;
        s_arvalid = 2'b01;
        m_arready = 1'b1;
        step();
        check("single_arvalid", m_arvalid, 1'b1);
        check("single_arid", m_arid, 4'd0);
        check("single_addr", m_ar_req.addr, 32'h8000_0040);
        s_arvalid = 2'b00;
        step();
        m_rvalid = 1'b1; m_rid = 4'd0; m_rlast = 1'b1; s_rready = 2'b01;
        m_rdata = {8{32'hA5A5_5A5A}};
        step();
        check("single_rvalid", obs_rvalid, 2'b01);
        check("single_rack", m_rack, 1'b1);
        m_rvalid = 1'b0;
        step();
        check("single_rack_off", m_rack, 1'b0);

        // Contention: both requesters valid every cycle
        do_reset();
        s_ar_req[0] = rand_req();
        s_ar_req[1] = rand_req();
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        s_rready  = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef ACE_RD_ARB_FIXED_PRIO_EN
            m_rvalid = (k > 0); m_rid = 4'd0; m_rlast = 1'b1;
            step();
            check("contention_grant", obs_ready, 2'b01);
`else
            step();
            check("contention_grant", obs_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
`endif
        end

        // Credit limit on requester 1
        do_reset();
        s_ar_req[1] = rand_req();
        s_arvalid = 2'b10;
        m_arready = 1'b1;
        step();
        step();
        step();
        check("credit_stall", obs_ready, 2'b00);
        m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b1; s_rready = 2'b10;
        step();
        check("credit_stall_on_last", obs_ready, 2'b00);
        m_rvalid = 1'b0;
        step();
        check("credit_resume", obs_ready, 2'b10);
        s_arvalid = 2'b00;
        step();

        // Simultaneous increment and decrement on requester 0
        do_reset();
        s_ar_req[0] = rand_req();
        s_arvalid = 2'b01;
        m_arready = 1'b1;
        step();
        m_rvalid = 1'b1; m_rid = 4'd0; m_rlast = 1'b1; s_rready = 2'b01;
        step();
        check("incdec_accept", obs_ready, 2'b01);
        m_rvalid = 1'b0;
        step();
        check("incdec_one_more", obs_ready, 2'b01);
        step();
        check("incdec_full", obs_ready, 2'b00);

        // Backpressure on the manager AR channel
        do_reset();
        s_ar_req[0] = rand_req();
        s_ar_req[1] = rand_req();
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_stall", obs_ready, 2'b00);
            check("bp_arid", m_arid, 4'd0);
        end
        m_arready = 1'b1;
        step();
`ifdef ACE_RD_ARB_FIXED_PRIO_EN
        check("bp_release", obs_ready, 2'b01);
`else
        check("bp_release", obs_ready, 2'b10);
`endif

        // Reset with reads outstanding
        step();
        rst = 1'b1;
        idle_inputs();
        step();
        check("rst_arvalid", m_arvalid, 1'b0);
        check("rst_rack", m_rack, 1'b0);
        rst = 1'b0;
        s_ar_req[0] = rand_req();
        s_arvalid = 2'b01;
        m_arready = 1'b1;
        step();
        check("post_rst_credit0", obs_ready, 2'b01);
        step();
        check("post_rst_credit1", obs_ready, 2'b01);

        // Random traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            drive_random();
            step();
        end

        idle_inputs();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
